bus_xfer_ctrl: RTL and testbench

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_onehot_dec.sv | 23 ++
 rtl/tri_state_buffer.sv | 14 +
 rtl/bus_xfer_ctrl.sv | 139 +++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus transfer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_N_PORT   = 4;
  localparam int DEF_TURN_CYC = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2,
    LATCH = 2'd3
  } xfer_state_t;

  // An index is usable only if it names an existing port.
  function automatic logic idx_ok(input int idx, input int n);
    return (idx >= 0) && (idx < n);
  endfunction

endpackage

// File: rtl/bus_onehot_dec.sv
// Index-to-one-hot decoder with enable; all zeros when disabled or index out of range.
// Latency: combinational.
// Backpressure: none.
module bus_onehot_dec #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  // Decode; out-of-range indices match no bit and leave the vector zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (int'(idx) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_state_buffer.sv
// Single tri-state driver onto a shared bus.
// Latency: combinational.
// Backpressure: none; releases the bus (Z) whenever en is low.
module tri_state_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output wire  [WIDTH-1:0] y
);

  assign y = en ? a : {WIDTH{1'bz}};

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer controller: turnaround, drive/settle, latch into destination.
// Latency: TURN_CYC+2 cycles from accept edge to the done pulse.
// Backpressure: req_ready only in IDLE; requests while busy are ignored. Optional XFER_COUNT_EN adds xfer_count.
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  N_PORT   = DEF_N_PORT,
  parameter int  TURN_CYC = DEF_TURN_CYC,
  localparam int IW       = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IW-1:0]     req_src,
  input  logic [IW-1:0]     req_dst,
  output logic [N_PORT-1:0] drv_en,
  input  logic [WIDTH-1:0]  bus_in,
  output logic [N_PORT-1:0] ld_en,
  output logic [WIDTH-1:0]  cap_data,
  output logic              done,
  output logic              busy
`ifdef XFER_COUNT_EN
  ,
  output logic [15:0]       xfer_count
`endif
);

  localparam int TL = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;
  localparam int CW = (TL > 0) ? $clog2(TL + 1) : 1;
  localparam logic [CW-1:0] TURN_LAST = CW'(TL);

  xfer_state_t state, state_nxt;

  logic [IW-1:0]     src_q, dst_q;
  logic              ok_q;
  logic [CW-1:0]     turn_cnt;
  logic              accept;
  logic              req_ok;
  logic [IW-1:0]     drv_idx;
  logic              drv_on, ld_on;
  logic [N_PORT-1:0] drv_nxt, ld_nxt;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  // A transfer with either index out of range runs its timeline but never touches the bus.
  assign req_ok    = idx_ok(int'(req_src), N_PORT) && idx_ok(int'(req_dst), N_PORT);

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: optional turnaround, one settle cycle, one latch cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (TURN_CYC == 0) ? DRIVE : TURN;
      TURN:    if (turn_cnt == TURN_LAST) state_nxt = DRIVE;
      DRIVE:   state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Count cycles spent in TURN so the bus stays idle exactly TURN_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     turn_cnt <= '0;
    else if ((state == TURN) && (state_nxt == TURN)) turn_cnt <= turn_cnt + CW'(1);
    else                                            turn_cnt <= '0;
  end

  // Hold the request indices for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      ok_q  <= 1'b0;
    end else if (accept) begin
      src_q <= req_src;
      dst_q <= req_dst;
      ok_q  <= req_ok;
    end
  end

  // Enables are decoded from the next state so the registered outputs line up with it;
  // with no turnaround the source comes straight from the request being accepted.
  always_comb begin
    drv_idx = accept ? req_src : src_q;
    drv_on  = ((state_nxt == DRIVE) || (state_nxt == LATCH)) && (accept ? req_ok : ok_q);
    ld_on   = (state_nxt == LATCH) && ok_q;
  end

  bus_onehot_dec #(.N(N_PORT), .IW(IW)) u_drv_dec (
    .idx    (drv_idx),
    .en     (drv_on),
    .onehot (drv_nxt)
  );

  bus_onehot_dec #(.N(N_PORT), .IW(IW)) u_ld_dec (
    .idx    (dst_q),
    .en     (ld_on),
    .onehot (ld_nxt)
  );

  // Registered bus enables; reset drops the drivers immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_en <= '0;
      ld_en  <= '0;
    end else begin
      drv_en <= drv_nxt;
      ld_en  <= ld_nxt;
    end
  end

  // Capture the bus at the close of LATCH and pulse done for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == LATCH);
      if ((state == LATCH) && ok_q) cap_data <= bus_in;
    end
  end

`ifdef XFER_COUNT_EN
  // Completed-transfer counter, advancing with each done pulse and wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              xfer_count <= '0;
    else if (state == LATCH) xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed plus randomized bench for bus_xfer_ctrl with tri-state drivers on a shared bus.
// Main instance: WIDTH=8, N_PORT=4, TURN_CYC=1. Second instance: N_PORT=3, TURN_CYC=0 (out-of-range indices).
// Expected timeline per accepted request is derived from the transfer rules, not the FSM encoding.
module tb_bus_xfer_ctrl;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TC  = 1;
  localparam int IW  = 2;
  localparam int N3  = 3;
  localparam int TC3 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_src = '0;
  logic [IW-1:0] req_dst = '0;
  logic [N-1:0]  drv_en, ld_en;
  logic [W-1:0]  cap_data;
  logic          done, busy;
  logic [N-1:0][W-1:0] buf_d = '0;
  tri   [W-1:0]  bus;

  // second instance
  logic          req_valid3 = 1'b0;
  logic          req_ready3;
  logic [IW-1:0] req_src3 = '0;
  logic [IW-1:0] req_dst3 = '0;
  logic [N3-1:0] drv_en3, ld_en3;
  logic [W-1:0]  bus3 = '0;
  logic [W-1:0]  cap_data3;
  logic          done3, busy3;

`ifdef XFER_COUNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  // model state
  logic [W-1:0] cap_model  = '0;
  logic [W-1:0] cap3_model = '0;
  logic [N-1:0] last_nz    = '0;
  int           gap        = 0;

  for (genvar g = 0; g < N; g++) begin : g_buf
    tri_state_buffer #(.WIDTH(W)) u_buf (
      .en (drv_en[g]),
      .a  (buf_d[g]),
      .y  (bus)
    );
  end

  bus_xfer_ctrl #(.WIDTH(W), .N_PORT(N), .TURN_CYC(TC)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .drv_en    (drv_en),
    .bus_in    (bus),
    .ld_en     (ld_en),
    .cap_data  (cap_data),
    .done      (done),
    .busy      (busy)
`ifdef XFER_COUNT_EN
    ,
    .xfer_count (cnt_a)
`endif
  );

  bus_xfer_ctrl #(.WIDTH(W), .N_PORT(N3), .TURN_CYC(TC3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_src   (req_src3),
    .req_dst   (req_dst3),
    .drv_en    (drv_en3),
    .bus_in    (bus3),
    .ld_en     (ld_en3),
    .cap_data  (cap_data3),
    .done      (done3),
    .busy      (busy3)
`ifdef XFER_COUNT_EN
    ,
    .xfer_count (cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // At most one driver, and a change of source needs TC idle cycles in between.
  task automatic bus_rules();
    chk("drv_onehot", 32'($countones(drv_en) <= 1), 1);
    if (drv_en != '0) begin
      if ((last_nz != '0) && (drv_en != last_nz)) chk("drv_gap", 32'(gap >= TC), 1);
      last_nz = drv_en;
      gap = 0;
    end else begin
      gap++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_drv", drv_en, 0);
      chk("idle_ld", ld_en, 0);
      chk("idle_ready", req_ready, 1);
      bus_rules();
      req_valid = 1'b0;
    end
  endtask

  // One transfer on the main instance. Entered just after a negedge; returns at the
  // negedge of its done cycle so a following call is accepted back-to-back.
  task automatic xfer(input int s, input int d, input bit junk, input int fd);
    logic [W-1:0] data;
    logic [N-1:0] e_drv, e_ld;
    for (int p = 0; p < N; p++) buf_d[p] = W'($urandom);
    if (fd >= 0) buf_d[s] = W'(fd);
    data = buf_d[s];
    chk("ready_pre", req_ready, 1);
    req_valid = 1'b1;
    req_src = IW'(s);
    req_dst = IW'(d);
    @(posedge clk);
    for (int c = 1; c <= TC + 3; c++) begin
      @(negedge clk);
      e_drv = '0;
      e_ld  = '0;
      if ((c == TC + 1) || (c == TC + 2)) e_drv[s] = 1'b1;
      if (c == TC + 2) e_ld[d] = 1'b1;
      chk("drv_en", drv_en, e_drv);
      chk("ld_en", ld_en, e_ld);
      chk("done", done, 32'(c == TC + 3));
      chk("busy", busy, 32'(c <= TC + 2));
      chk("ready", req_ready, 32'(c == TC + 3));
      if (c == TC + 2) chk("bus_val", bus, data);
      if (c == TC + 3) begin
        cap_model = data;
        chk("cap_data", cap_data, cap_model);
      end
      bus_rules();
      if (junk && (c < TC + 3)) begin
        req_valid = 1'b1;
        req_src = IW'((s + 1 + $urandom_range(0, 2)) % N);
        req_dst = IW'($urandom_range(0, N - 1));
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  // One transfer on the no-turnaround, three-port instance; indices may be out of range.
  task automatic xfer3(input int s, input int d);
    bit ok;
    logic [N3-1:0] e_drv, e_ld;
    ok = (s < N3) && (d < N3);
    bus3 = W'($urandom);
    chk("ready3_pre", req_ready3, 1);
    req_valid3 = 1'b1;
    req_src3 = IW'(s);
    req_dst3 = IW'(d);
    @(posedge clk);
    for (int c = 1; c <= TC3 + 3; c++) begin
      @(negedge clk);
      req_valid3 = 1'b0;
      e_drv = '0;
      e_ld  = '0;
      if (ok && ((c == TC3 + 1) || (c == TC3 + 2))) e_drv[s] = 1'b1;
      if (ok && (c == TC3 + 2)) e_ld[d] = 1'b1;
      chk("drv_en3", drv_en3, e_drv);
      chk("ld_en3", ld_en3, e_ld);
      chk("done3", done3, 32'(c == TC3 + 3));
      chk("busy3", busy3, 32'(c <= TC3 + 2));
      if (c == TC3 + 3) begin
        if (ok) cap3_model = bus3;
        chk("cap_data3", cap_data3, cap3_model);
      end
    end
  endtask

  initial begin
    // reset values while rst_n is low
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drv", drv_en, 0);
    chk("rst_ld", ld_en, 0);
    chk("rst_cap", cap_data, 0);
    chk("rst_ready3", req_ready3, 1);
    chk("rst_cap3", cap_data3, 0);
`ifdef XFER_COUNT_EN
    chk("rst_cnt", cnt_a, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // basic: src 2 -> dst 1
    xfer(2, 1, 1'b0, 'hA5);
    idle(2);

    // back-to-back, different sources
    xfer(0, 1, 1'b0, 'h3C);
    xfer(3, 2, 1'b0, 'hC3);
    idle(1);

    // self-transfer
    xfer(3, 3, 1'b0, 'h7E);
    idle(1);

    // requests held high while busy must be ignored
    xfer(1, 0, 1'b1, -1);
    idle(2);

    // randomized transfers, some back-to-back, some with junk requests
    for (int k = 0; k < 12; k++) begin
      xfer($urandom_range(0, N - 1), $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    // reset in DRIVE releases the bus at once and suppresses done
    buf_d[1] = 8'h5A;
    req_valid = 1'b1;
    req_src = 2'd1;
    req_dst = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_drv", drv_en, 4'b0010);
    chk("pre_rst_bus", bus, 8'h5A);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_drv", drv_en, 0);
    chk("rst_mid_ld", ld_en, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    cap_model = '0;
    cap3_model = '0;
    last_nz = '0;
    gap = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_done", done, 0);
      chk("rst_hold_drv", drv_en, 0);
    end
    rst_n = 1'b1;
    idle(3);
    chk("rst_cap_clear", cap_data, cap_model);

    // second instance: no turnaround, in-range and out-of-range indices
    xfer3(1, 2);
    xfer3(0, 0);
    xfer3(3, 1);
    xfer3(2, 3);
    xfer3(2, 0);

`ifdef XFER_COUNT_EN
    // 65537 back-to-back transfers wrap the counter to 1
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("cnt_rst", cnt_b, 0);
    req_valid3 = 1'b1;
    req_src3 = 2'd0;
    req_dst3 = 2'd0;
    repeat (65537 * 3) @(posedge clk);
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("cnt_wrap", cnt_b, 1);
    chk("cnt_other", cnt_a, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
